// File: rtl/spill_fifo_flushable.sv
// Flushable elastic buffer with registered handshake flags, occupancy and almost-full.
// Generalises the two-entry spill register to any depth; Bypass makes it a wire.
module spill_fifo_flushable #(
  parameter type         T                = logic,
  parameter int unsigned Depth            = 2,
  parameter int unsigned AlmostFullThresh = Depth - 1,
  parameter bit          Bypass           = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  T                             data_i,
  output logic                         valid_o,
  input  logic                         ready_i,
  output T                             data_o,
  output logic [$clog2(Depth+1)-1:0]   count_o,
  output logic                         almost_full_o
);

  localparam int unsigned PW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CW = $clog2(Depth + 1);

  // Depth need not be a power of two, so wrap explicitly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(Depth - 1)) ? '0 : p + PW'(1);
  endfunction

  if (Bypass) begin : g_bypass
    assign valid_o       = valid_i;
    assign ready_o       = ready_i;
    assign data_o        = data_i;
    assign count_o       = '0;
    assign almost_full_o = 1'b0;
  end else begin : g_fifo
    T              mem [Depth];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_next;
    logic          push;
    logic          pop;

    assign push = valid_i && ready_o && !flush_i;
    // A pop in a flush cycle still counts: downstream took that entry.
    assign pop  = valid_o && ready_i;

    always_comb begin
      count_next = count_q;
      if (flush_i) begin
        count_next = '0;
      end else if (push && !pop) begin
        count_next = count_q + CW'(1);
      end else if (pop && !push) begin
        count_next = count_q - CW'(1);
      end
    end

    // Storage is not reset; flags keep stale entries invisible.
    always_ff @(posedge clk) begin
      if (push) begin
        mem[wr_ptr] <= data_i;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_ptr        <= '0;
        wr_ptr        <= '0;
        count_q       <= '0;
        valid_o       <= 1'b0;
        ready_o       <= 1'b0;
        almost_full_o <= 1'b0;
      end else begin
        if (flush_i) begin
          rd_ptr <= '0;
          wr_ptr <= '0;
        end else begin
          if (push) wr_ptr <= ptr_inc(wr_ptr);
          if (pop)  rd_ptr <= ptr_inc(rd_ptr);
        end
        count_q       <= count_next;
        valid_o       <= (count_next != '0);
        ready_o       <= (count_next != CW'(Depth));
        almost_full_o <= (count_next >= CW'(AlmostFullThresh));
      end
    end

    assign count_o = count_q;
    assign data_o  = mem[rd_ptr];

    // Upstream should not offer data while flushing; that beat is dropped.
    assert property (@(posedge clk) disable iff (!rst_n) !(flush_i && valid_i))
      else $warning("spill_fifo_flushable: valid_i during flush, beat discarded");
  end

endmodule

// File: tb/tb_spill_fifo_flushable.sv
// Scoreboard bench: Depth=4 main instance, Depth=2 streaming, Depth=3 wrap, Bypass instance.
module tb_spill_fifo_flushable;

  logic clk;
  logic rst_n;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Depth=4 instance
  logic       a_flush, a_vin, a_rdy, a_vout, a_rin, a_af;
  logic [7:0] a_din, a_dout;
  logic [2:0] a_cnt;
  // Depth=2 instance
  logic       b_flush, b_vin, b_rdy, b_vout, b_rin, b_af;
  logic [7:0] b_din, b_dout;
  logic [1:0] b_cnt;
  // Depth=3 instance
  logic       c_flush, c_vin, c_rdy, c_vout, c_rin, c_af;
  logic [7:0] c_din, c_dout;
  logic [1:0] c_cnt;
  // Bypass instance
  logic       d_flush, d_vin, d_rdy, d_vout, d_rin, d_af;
  logic [7:0] d_din, d_dout;
  logic [1:0] d_cnt;

  spill_fifo_flushable #(.T(logic [7:0]), .Depth(4)) u_a (
    .clk(clk), .rst_n(rst_n), .flush_i(a_flush), .valid_i(a_vin), .ready_o(a_rdy),
    .data_i(a_din), .valid_o(a_vout), .ready_i(a_rin), .data_o(a_dout),
    .count_o(a_cnt), .almost_full_o(a_af));

  spill_fifo_flushable #(.T(logic [7:0]), .Depth(2)) u_b (
    .clk(clk), .rst_n(rst_n), .flush_i(b_flush), .valid_i(b_vin), .ready_o(b_rdy),
    .data_i(b_din), .valid_o(b_vout), .ready_i(b_rin), .data_o(b_dout),
    .count_o(b_cnt), .almost_full_o(b_af));

  spill_fifo_flushable #(.T(logic [7:0]), .Depth(3)) u_c (
    .clk(clk), .rst_n(rst_n), .flush_i(c_flush), .valid_i(c_vin), .ready_o(c_rdy),
    .data_i(c_din), .valid_o(c_vout), .ready_i(c_rin), .data_o(c_dout),
    .count_o(c_cnt), .almost_full_o(c_af));

  spill_fifo_flushable #(.T(logic [7:0]), .Depth(2), .Bypass(1'b1)) u_d (
    .clk(clk), .rst_n(rst_n), .flush_i(d_flush), .valid_i(d_vin), .ready_o(d_rdy),
    .data_i(d_din), .valid_o(d_vout), .ready_i(d_rin), .data_o(d_dout),
    .count_o(d_cnt), .almost_full_o(d_af));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  logic [7:0] qa[$], qb[$], qc[$];
  int         a_pops = 0, b_pops = 0, c_pops = 0, c_pushed = 0, a_pushed = 0;
  logic       a_hold;
  logic [7:0] a_hold_d;

  // Monitors sample mid-cycle: a handshake seen here completes at the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      qa.delete(); qb.delete(); qc.delete();
      a_hold = 1'b0;
    end else begin
      if (a_hold && a_vout) check_val("a_stall_stable", 32'(a_dout), 32'(a_hold_d));
      if (a_vout && a_rin) begin
        if (qa.size() == 0) check_val("a_spurious_pop", 32'(qa.size()), 32'd1);
        else check_val("a_data", 32'(a_dout), 32'(qa.pop_front()));
        a_pops++;
      end
      if (a_flush) qa.delete();
      if (a_vin && a_rdy && !a_flush) begin
        qa.push_back(a_din);
        a_pushed++;
      end
      a_hold   = a_vout && !a_rin;
      a_hold_d = a_dout;

      if (b_vout && b_rin) begin
        if (qb.size() == 0) check_val("b_spurious_pop", 32'(qb.size()), 32'd1);
        else check_val("b_data", 32'(b_dout), 32'(qb.pop_front()));
        b_pops++;
      end
      if (b_flush) qb.delete();
      if (b_vin && b_rdy && !b_flush) qb.push_back(b_din);

      if (c_vout && c_rin) begin
        if (qc.size() == 0) check_val("c_spurious_pop", 32'(qc.size()), 32'd1);
        else check_val("c_data", 32'(c_dout), 32'(qc.pop_front()));
        c_pops++;
      end
      if (c_flush) qc.delete();
      if (c_vin && c_rdy && !c_flush) begin
        qc.push_back(c_din);
        c_pushed++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain_a(input string tag);
    a_vin = 1'b0;
    a_rin = 1'b1;
    for (int k = 0; k < 40 && a_cnt != 3'd0; k++) step();
    check_val({tag, "_cnt"}, 32'(a_cnt), 32'd0);
    check_val({tag, "_vout"}, 32'(a_vout), 32'd0);
  endtask

  int p0;

  initial begin
    rst_n = 1'b0;
    {a_flush, a_vin, a_rin, b_flush, b_vin, b_rin} = '0;
    {c_flush, c_vin, c_rin, d_flush, d_vin, d_rin} = '0;
    a_din = '0; b_din = '0; c_din = '0; d_din = '0;

    // Reset state, and ready_o rising one edge after release
    #2;
    check_val("rst_vout", 32'(a_vout), 32'd0);
    check_val("rst_rdy", 32'(a_rdy), 32'd0);
    check_val("rst_cnt", 32'(a_cnt), 32'd0);
    check_val("rst_af", 32'(a_af), 32'd0);
    #10 rst_n = 1'b1;
    #1 check_val("rel_rdy_before_edge", 32'(a_rdy), 32'd0);
    step();
    check_val("rel_rdy_after_edge", 32'(a_rdy), 32'd1);

    // Fill Depth=4 with downstream stalled
    a_vin = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_din = 8'(8'h10 + i);
      step();
      check_val("fill_cnt", 32'(a_cnt), 32'(i + 1));
      check_val("fill_af", 32'(a_af), (i + 1 >= 3) ? 32'd1 : 32'd0);
      check_val("fill_rdy", 32'(a_rdy), (i + 1 == 4) ? 32'd0 : 32'd1);
      check_val("fill_vout", 32'(a_vout), 32'd1);
    end
    p0 = a_pops;
    drain_a("fill_drain");
    check_val("fill_pops", 32'(a_pops - p0), 32'd4);

    // Streaming, Depth=2
    b_vin = 1'b1;
    b_rin = 1'b1;
    for (int i = 0; i < 100; i++) begin
      b_din = 8'(i);
      step();
      check_val("stream_cnt", 32'(b_cnt), 32'd1);
      check_val("stream_rdy", 32'(b_rdy), 32'd1);
    end
    b_vin = 1'b0;
    step();
    b_rin = 1'b0;
    check_val("stream_pops", 32'(b_pops), 32'd100);
    check_val("stream_cnt_end", 32'(b_cnt), 32'd0);

    // Backpressure: three held entries, then random ready_i and sporadic pushes
    a_rin = 1'b0;
    a_vin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_din = 8'(8'h20 + i);
      step();
    end
    check_val("stall_cnt3", 32'(a_cnt), 32'd3);
    for (int i = 0; i < 40; i++) begin
      a_vin = 1'($urandom_range(0, 1));
      a_din = 8'(8'h40 + a_pushed);
      a_rin = 1'($urandom_range(0, 1));
      step();
    end
    drain_a("stall_drain");

    // Flush mid-stream: 0xA leaves in the flush cycle, 0xB/0xC are dropped
    a_rin = 1'b0;
    a_vin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_din = 8'(8'h0A + i);
      step();
    end
    a_vin = 1'b0;
    check_val("flush_pre_cnt", 32'(a_cnt), 32'd3);
    p0 = a_pops;
    a_flush = 1'b1;
    a_rin = 1'b1;
    step();
    a_flush = 1'b0;
    a_rin = 1'b0;
    check_val("flush_pop_counted", 32'(a_pops - p0), 32'd1);
    check_val("flush_vout", 32'(a_vout), 32'd0);
    check_val("flush_cnt", 32'(a_cnt), 32'd0);
    check_val("flush_rdy", 32'(a_rdy), 32'd1);
    check_val("flush_af", 32'(a_af), 32'd0);
    a_vin = 1'b1;
    a_din = 8'h0D;
    step();
    a_vin = 1'b0;
    check_val("flush_next_vout", 32'(a_vout), 32'd1);
    check_val("flush_next_data", 32'(a_dout), 32'h0D);
    drain_a("flush_drain");
    a_flush = 1'b1;
    step();
    a_flush = 1'b0;
    check_val("flush_empty_cnt", 32'(a_cnt), 32'd0);
    check_val("flush_empty_rdy", 32'(a_rdy), 32'd1);

    // Asynchronous reset between edges with two entries held
    a_rin = 1'b0;
    a_vin = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a_din = 8'(8'h50 + i);
      step();
    end
    a_vin = 1'b0;
    check_val("arst_pre_cnt", 32'(a_cnt), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_vout", 32'(a_vout), 32'd0);
    check_val("arst_rdy", 32'(a_rdy), 32'd0);
    check_val("arst_cnt", 32'(a_cnt), 32'd0);
    #3 rst_n = 1'b1;
    #1 check_val("arst_rdy_before_edge", 32'(a_rdy), 32'd0);
    step();
    check_val("arst_rdy_after_edge", 32'(a_rdy), 32'd1);
    check_val("arst_vout_after", 32'(a_vout), 32'd0);

    // Depth=3 wrap with random gaps on both sides
    for (int k = 0; k < 400 && c_pops < 10; k++) begin
      c_vin = (c_pushed < 10) && 1'($urandom_range(0, 1));
      c_din = 8'(8'h30 + c_pushed);
      c_rin = 1'($urandom_range(0, 1));
      step();
    end
    c_vin = 1'b0;
    c_rin = 1'b0;
    check_val("wrap_pushed", 32'(c_pushed), 32'd10);
    check_val("wrap_pops", 32'(c_pops), 32'd10);
    check_val("wrap_cnt", 32'(c_cnt), 32'd0);

    // Bypass: combinational pass-through
    for (int i = 0; i < 4; i++) begin
      d_vin = 1'(i);
      d_rin = 1'(i >> 1);
      d_din = 8'($urandom_range(0, 255));
      #1;
      check_val("byp_vout", 32'(d_vout), 32'(d_vin));
      check_val("byp_rdy", 32'(d_rdy), 32'(d_rin));
      check_val("byp_data", 32'(d_dout), 32'(d_din));
      check_val("byp_cnt", 32'(d_cnt), 32'd0);
      check_val("byp_af", 32'(d_af), 32'd0);
    end

    step();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
